fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  load-use stall from hazard unit; hold IF/ID.
REQ-005 SHALL have port flush  input  1  branch-taken flush from hazard unit; kill IF/ID, redirect.
REQ-006 SHALL have port branch_target  input  32  redirect address, valid when flush=1.
REQ-007 SHALL have port imem_req  output  1  instruction fetch request.
REQ-008 SHALL have port imem_addr  output  32  fetch address; stable while imem_req=1 until imem_ready.
REQ-009 SHALL have port imem_ready  input  1  response valid this cycle; ignored when imem_req=0.
REQ-010 SHALL have port imem_rdata  input  32  instruction word, valid with imem_ready.
REQ-011 SHALL have port IF_ID_pc  output  32  PC of instruction in IF/ID.
REQ-012 SHALL have port IF_ID_inst  output  32  instruction in IF/ID.
REQ-013 SHALL have port IF_ID_valid  output  1  IF/ID holds a real instruction.

Function
REQ-014 SHALL implement FSM states FETCH, HOLD, DISCARD; imem_req=1 in FETCH and DISCARD, 0 in HOLD.
REQ-015 SHALL drive imem_addr from register fetch_pc (address of outstanding request).
REQ-016 FETCH, imem_ready=1, stall=0, flush=0: IF_ID <= {fetch_pc, imem_rdata, valid=1}; fetch_pc <= fetch_pc+4 (wraps mod 2^32); stay FETCH.
REQ-017 FETCH, imem_ready=1, stall=1, flush=0: capture {fetch_pc, imem_rdata} in hold buffer; fetch_pc+4; IF_ID unchanged; go HOLD.
REQ-018 FETCH, imem_ready=0, flush=0: stall=0 -> IF_ID_valid<=0, IF_ID_inst<=NOP (bubble); stall=1 -> IF_ID unchanged.
REQ-019 HOLD, stall=0, flush=0: IF_ID <= hold buffer, valid=1; go FETCH. stall=1: remain HOLD.
REQ-020 flush SHALL take priority over stall in every state; on flush IF_ID_valid<=0, IF_ID_inst<=NOP next cycle.
REQ-021 flush in FETCH with imem_ready=1, or in HOLD: drop data/buffer; fetch_pc<=branch_target; go/stay FETCH.
REQ-022 flush in FETCH with imem_ready=0: redirect_pc<=branch_target; go DISCARD; imem_addr unchanged.
REQ-023 DISCARD: keep request; on imem_ready drop data, fetch_pc<=redirect_pc, go FETCH; IF_ID_valid stays 0.
REQ-024 flush in DISCARD SHALL overwrite redirect_pc with the newest branch_target.
REQ-025 Fetch-to-IF/ID latency SHALL be one cycle after imem_ready; zero-wait memory sustains one instruction per cycle.
REQ-026 No instruction SHALL be lost or duplicated across any stall sequence.

Reset
REQ-027 reset=1: state FETCH, fetch_pc=RESET_PC, IF_ID_pc=0, IF_ID_inst=NOP, IF_ID_valid=0, hold buffer cleared, imem_req=0 that cycle.
REQ-028 reset mid-request SHALL abandon the request; first post-reset request at RESET_PC.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN: when defined, SHALL add outputs stall_count[31:0] (cycles stall=1 and flush=0) and flush_count[31:0] (cycles flush=1), both reset to 0, saturating at 32'hFFFF_FFFF.
REQ-030 Without FETCH_PERF_CNT_EN, SHALL omit these ports and counters; all other behaviour identical.

Structure
REQ-031 Shared package pipe_pkg SHALL hold XLEN=32, NOP_INST=32'h0000_0013, and the fetch state enum.
REQ-032 IF/ID register (load/hold/bubble control) SHALL be sub-module if_id_reg.

Verification
REQ-033 Reset, imem_ready always 1 -> addresses 0,4,8,...; IF_ID_pc trails imem_addr by one cycle, valid=1 from cycle 2.
REQ-034 stall=1 for 3 cycles while imem_ready=1 at 0x8 -> state HOLD, IF_ID frozen at 0x4, then IF_ID_pc=0x8, no repeat/skip.
REQ-035 flush=1 with branch_target=0x100, imem_ready=1 -> next cycle IF_ID_valid=0, imem_addr=0x100.
REQ-036 flush with target 0x200 while imem_ready=0 for 2 cycles -> imem_addr held, response dropped, then imem_addr=0x200.
REQ-037 stall=1 and flush=1 together (target 0x40) -> flush wins, IF_ID bubble, next fetch 0x40.
REQ-038 FETCH_PERF_CNT_EN defined, 5 stall cycles and 2 flush cycles -> stall_count=5, flush_count=2; reset -> both 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: data width, the canonical NOP encoding and the
// fetch FSM state type.
package pipe_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and bubble control.
// A bubble clears valid and inserts a NOP, leaving the PC field as it was.
module if_id_reg
    import pipe_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] inst_in,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] inst,
    output logic            valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= '0;
            inst  <= NOP_INST;
            valid <= 1'b0;
        end else if (bubble) begin
            inst  <= NOP_INST;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= pc_in;
            inst  <= inst_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: request sequencing, stall hold buffer, flush redirect.
// Optional stall/flush performance counters when FETCH_PERF_CNT_EN is defined.
//
// state   | meaning
// FETCH   | request at fetch_pc outstanding; response goes to IF/ID
// HOLD    | response captured during stall; no request until released
// DISCARD | in-flight request belongs to a flushed path; drop its response
module fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [XLEN-1:0] IF_ID_inst,
    output logic            IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     stall_count,
    output logic [31:0]     flush_count
`endif
);

    fetch_state_e    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] hold_inst;

    logic            if_load;
    logic            if_bubble;
    logic [XLEN-1:0] if_pc_in;
    logic [XLEN-1:0] if_inst_in;

    assign imem_req  = !reset && (state != HOLD);
    assign imem_addr = fetch_pc;

    always_comb begin
        if_load    = 1'b0;
        if_bubble  = 1'b0;
        if_pc_in   = fetch_pc;
        if_inst_in = imem_rdata;
        unique case (state)
            FETCH: begin
                if (flush)
                    if_bubble = 1'b1;
                else if (!stall && imem_ready)
                    if_load = 1'b1;
                else if (!stall)
                    if_bubble = 1'b1;
            end
            HOLD: begin
                if (flush) begin
                    if_bubble = 1'b1;
                end else if (!stall) begin
                    if_load    = 1'b1;
                    if_pc_in   = hold_pc;
                    if_inst_in = hold_inst;
                end
            end
            default: if_bubble = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            redirect_pc <= RESET_PC;
            hold_pc     <= '0;
            hold_inst   <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (flush) begin
                        if (imem_ready) begin
                            fetch_pc <= branch_target;
                        end else begin
                            redirect_pc <= branch_target;
                            state       <= DISCARD;
                        end
                    end else if (imem_ready) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        if (stall) begin
                            hold_pc   <= fetch_pc;
                            hold_inst <= imem_rdata;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (flush) begin
                        fetch_pc  <= branch_target;
                        hold_pc   <= '0;
                        hold_inst <= '0;
                        state     <= FETCH;
                    end else if (!stall) begin
                        state <= FETCH;
                    end
                end
                DISCARD: begin
                    // A flush racing the stale response redirects straight to the newest target.
                    if (flush && imem_ready) begin
                        fetch_pc <= branch_target;
                        state    <= FETCH;
                    end else if (flush) begin
                        redirect_pc <= branch_target;
                    end else if (imem_ready) begin
                        fetch_pc <= redirect_pc;
                        state    <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (if_load),
        .bubble  (if_bubble),
        .pc_in   (if_pc_in),
        .inst_in (if_inst_in),
        .pc      (IF_ID_pc),
        .inst    (IF_ID_inst),
        .valid   (IF_ID_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && !flush && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
            if (flush && (flush_count != 32'hFFFF_FFFF))
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a simple memory model
// returning 0xA500_0000 ^ address. Exercises perf counters when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic        IF_ID_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .IF_ID_pc      (IF_ID_pc),
        .IF_ID_inst    (IF_ID_inst),
        .IF_ID_valid   (IF_ID_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_count   (stall_count),
        .flush_count   (flush_count)
`endif
    );

    // ctl = {stall, flush, imem_ready}; req/addr checked before the edge, IF_ID after it
    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } vec_t;

    vec_t vecs[32];
    int   nvec = 0;

    task automatic add(input logic [2:0] ctl, input logic [31:0] tgt, input logic req,
                       input logic [31:0] addr, input logic [31:0] pc,
                       input logic [31:0] inst, input logic valid);
        vecs[nvec] = '{ctl, tgt, req, addr, pc, inst, valid};
        nvec++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0;
        imem_ready = 1'b0; imem_rdata = '0;

        //   ctl     tgt            req   addr           pc             inst           valid
        add(3'b001, 32'h0,         1'b1, 32'h0000_0000, 32'h0000_0000, 32'hA500_0000, 1'b1);
        add(3'b001, 32'h0,         1'b1, 32'h0000_0004, 32'h0000_0004, 32'hA500_0004, 1'b1);
        add(3'b101, 32'h0,         1'b1, 32'h0000_0008, 32'h0000_0004, 32'hA500_0004, 1'b1);
        add(3'b101, 32'h0,         1'b0, 32'h0000_000C, 32'h0000_0004, 32'hA500_0004, 1'b1);
        add(3'b101, 32'h0,         1'b0, 32'h0000_000C, 32'h0000_0004, 32'hA500_0004, 1'b1);
        add(3'b001, 32'h0,         1'b0, 32'h0000_000C, 32'h0000_0008, 32'hA500_0008, 1'b1);
        add(3'b001, 32'h0,         1'b1, 32'h0000_000C, 32'h0000_000C, 32'hA500_000C, 1'b1);
        add(3'b011, 32'h100,       1'b1, 32'h0000_0010, 32'h0000_000C, NOP_INST,      1'b0);
        add(3'b001, 32'h0,         1'b1, 32'h0000_0100, 32'h0000_0100, 32'hA500_0100, 1'b1);
        add(3'b000, 32'h0,         1'b1, 32'h0000_0104, 32'h0000_0100, NOP_INST,      1'b0);
        add(3'b010, 32'h200,       1'b1, 32'h0000_0104, 32'h0000_0100, NOP_INST,      1'b0);
        add(3'b000, 32'h0,         1'b1, 32'h0000_0104, 32'h0000_0100, NOP_INST,      1'b0);
        add(3'b001, 32'h0,         1'b1, 32'h0000_0104, 32'h0000_0100, NOP_INST,      1'b0);
        add(3'b001, 32'h0,         1'b1, 32'h0000_0200, 32'h0000_0200, 32'hA500_0200, 1'b1);
        add(3'b111, 32'h40,        1'b1, 32'h0000_0204, 32'h0000_0200, NOP_INST,      1'b0);
        add(3'b001, 32'h0,         1'b1, 32'h0000_0040, 32'h0000_0040, 32'hA500_0040, 1'b1);
        add(3'b100, 32'h0,         1'b1, 32'h0000_0044, 32'h0000_0040, 32'hA500_0040, 1'b1);
        add(3'b001, 32'h0,         1'b1, 32'h0000_0044, 32'h0000_0044, 32'hA500_0044, 1'b1);
        add(3'b010, 32'h300,       1'b1, 32'h0000_0048, 32'h0000_0044, NOP_INST,      1'b0);
        add(3'b010, 32'h380,       1'b1, 32'h0000_0048, 32'h0000_0044, NOP_INST,      1'b0);
        add(3'b001, 32'h0,         1'b1, 32'h0000_0048, 32'h0000_0044, NOP_INST,      1'b0);
        add(3'b001, 32'h0,         1'b1, 32'h0000_0380, 32'h0000_0380, 32'hA500_0380, 1'b1);
        add(3'b101, 32'h0,         1'b1, 32'h0000_0384, 32'h0000_0380, 32'hA500_0380, 1'b1);
        add(3'b111, 32'h500,       1'b0, 32'h0000_0388, 32'h0000_0380, NOP_INST,      1'b0);
        add(3'b001, 32'h0,         1'b1, 32'h0000_0500, 32'h0000_0500, 32'hA500_0500, 1'b1);
        add(3'b011, 32'hFFFF_FFFC, 1'b1, 32'h0000_0504, 32'h0000_0500, NOP_INST,      1'b0);
        add(3'b001, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h5AFF_FFFC, 1'b1);
        add(3'b001, 32'h0,         1'b1, 32'h0000_0000, 32'h0000_0000, 32'hA500_0000, 1'b1);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req",   {31'b0, imem_req},    32'h0);
        check("rst_addr",  imem_addr,            32'h0);
        check("rst_pc",    IF_ID_pc,             32'h0);
        check("rst_inst",  IF_ID_inst,           NOP_INST);
        check("rst_valid", {31'b0, IF_ID_valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_stall_cnt", stall_count, 32'h0);
        check("rst_flush_cnt", flush_count, 32'h0);
`endif
        reset = 1'b0;

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            stall         = vecs[i].ctl[2];
            flush         = vecs[i].ctl[1];
            imem_ready    = vecs[i].ctl[0];
            branch_target = vecs[i].tgt;
            imem_rdata    = 32'hA500_0000 ^ imem_addr;
            #1;
            check($sformatf("v%0d_req", i),  {31'b0, imem_req}, {31'b0, vecs[i].req});
            check($sformatf("v%0d_addr", i), imem_addr,         vecs[i].addr);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pc", i),    IF_ID_pc,             vecs[i].pc);
            check($sformatf("v%0d_inst", i),  IF_ID_inst,           vecs[i].inst);
            check($sformatf("v%0d_valid", i), {31'b0, IF_ID_valid}, {31'b0, vecs[i].valid});
        end

        // Reset while a request is outstanding: abandon it, restart at RESET_PC
        @(negedge clk);
        stall = 1'b0; flush = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_req", {31'b0, imem_req}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_req_after",  {31'b0, imem_req},    32'h1);
        check("midrst_addr_after", imem_addr,            32'h0);
        check("midrst_valid",      {31'b0, IF_ID_valid}, 32'h0);
        check("midrst_inst",       IF_ID_inst,           NOP_INST);
        imem_ready = 1'b1;
        imem_rdata = 32'hA500_0000 ^ imem_addr;
        @(posedge clk);
        #1;
        check("midrst_first_pc",    IF_ID_pc,             32'h0);
        check("midrst_first_valid", {31'b0, IF_ID_valid}, 32'h1);

`ifdef FETCH_PERF_CNT_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            stall = 1'b1; flush = 1'b0; imem_ready = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            stall = 1'b0; flush = 1'b1; imem_ready = 1'b1; branch_target = 32'h0;
        end
        @(negedge clk);
        stall = 1'b0; flush = 1'b0; imem_ready = 1'b0;
        #1;
        check("perf_stall_cnt", stall_count, 32'd5);
        check("perf_flush_cnt", flush_count, 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check("perf_rst_stall_cnt", stall_count, 32'h0);
        check("perf_rst_flush_cnt", flush_count, 32'h0);
        reset = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
